// File: rtl/pong_engine_if.sv
// Raster, paddle and serve inputs plus colour, score and state outputs of the pong engine.
// The master side drives the controls and raster position; the slave side is the engine.
interface pong_engine_if;
    logic [7:0]  PADDLE_L_POS;
    logic [7:0]  PADDLE_R_POS;
    logic        SERVE;
    logic [10:0] PIXEL_H;
    logic [10:0] PIXEL_V;
    logic [2:0]  PIXEL;
    logic [3:0]  SCORE_L;
    logic [3:0]  SCORE_R;
    logic [1:0]  STATE;

    modport master (
        output PADDLE_L_POS, PADDLE_R_POS, SERVE, PIXEL_H, PIXEL_V,
        input  PIXEL, SCORE_L, SCORE_R, STATE
    );

    modport slave (
        input  PADDLE_L_POS, PADDLE_R_POS, SERVE, PIXEL_H, PIXEL_V,
        output PIXEL, SCORE_L, SCORE_R, STATE
    );
endinterface

// File: rtl/pong_engine.sv
// Pong engine: paddle clamping, ball motion per tick, scoring FSM and registered pixel colour.
// PIXEL follows PIXEL_H/V by one cycle; no backpressure, the raster free-runs.
module pong_engine #(
    parameter int H_ACTIVE    = 780,
    parameter int V_ACTIVE    = 480,
    parameter int BORDER      = 5,
    parameter int PADDLE_W    = 11,
    parameter int PADDLE_LEN  = 76,
    parameter int BALL_SIZE   = 17,
    parameter int TICK_DIV    = 91072,
    parameter int WIN_SCORE   = 7,
    parameter int PAUSE_TICKS = 64
) (
    input  logic         VGA_CLOCK,
    input  logic         RESET,
    pong_engine_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_POINT = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int TW   = $clog2(TICK_DIV + 1);
    localparam int PCW  = $clog2(PAUSE_TICKS + 1);
    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [PCW-1:0] PAUSE_LAST = PCW'(PAUSE_TICKS - 1);
    localparam logic [3:0]  WIN4    = 4'(WIN_SCORE);
    localparam logic [10:0] H_A     = 11'(H_ACTIVE);
    localparam logic [10:0] V_A     = 11'(V_ACTIVE);
    localparam logic [10:0] BRD     = 11'(BORDER);
    localparam logic [10:0] BS      = 11'(BALL_SIZE);
    localparam logic [10:0] PW      = 11'(PADDLE_W);
    localparam logic [10:0] PL      = 11'(PADDLE_LEN);
    localparam logic [10:0] CTR_H   = 11'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] CTR_V   = 11'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] LPAD_X  = 11'(BORDER + 5);
    localparam logic [10:0] RPAD_X  = 11'(H_ACTIVE - BORDER - 5 - PADDLE_W);
    localparam logic [10:0] TOP_MAX = 11'(V_ACTIVE - BORDER - PADDLE_LEN);
    localparam logic [10:0] R_LIM   = 11'(H_ACTIVE - BORDER);
    localparam logic [10:0] B_LIM   = 11'(V_ACTIVE - BORDER);
    localparam logic [10:0] BOT_LIM = 11'(V_ACTIVE - 1 - BORDER);
    localparam logic [10:0] NET_L   = 11'(H_ACTIVE / 2 - 1);
    localparam logic [10:0] NET_R   = 11'(H_ACTIVE / 2);

    state_t          state_q;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [PCW-1:0]  pause_q;
    logic [10:0]     ball_h_q, ball_v_q;
    logic            dh_q, dv_q, dh_d, dv_d;
    logic [3:0]      score_l_q, score_r_q;
    logic            serve_prev_q;
    logic [10:0]     pad_l_top_q, pad_r_top_q, pad_l_top_d, pad_r_top_d;
    logic [2:0]      pixel_q, pixel_d;
    logic            tick, ovl_l, ovl_r, miss_l, miss_r, bounce_l, bounce_r;
    logic            in_area, on_border, on_ball, on_pad, on_net;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Position code is doubled so 8 bits span the full playfield height.
    always_comb begin
        pad_l_top_d = {2'b00, bus.PADDLE_L_POS, 1'b0};
        pad_r_top_d = {2'b00, bus.PADDLE_R_POS, 1'b0};
        if (pad_l_top_d > TOP_MAX) pad_l_top_d = TOP_MAX;
        if (pad_r_top_d > TOP_MAX) pad_r_top_d = TOP_MAX;
    end

    assign ovl_l    = (ball_v_q < pad_l_top_q + PL) && (ball_v_q + BS > pad_l_top_q);
    assign ovl_r    = (ball_v_q < pad_r_top_q + PL) && (ball_v_q + BS > pad_r_top_q);
    assign miss_l   = (ball_h_q <= BRD);
    assign miss_r   = (ball_h_q + BS >= R_LIM);
    assign bounce_l = !dh_q && (ball_h_q == LPAD_X + PW) && ovl_l;
    assign bounce_r =  dh_q && (ball_h_q + BS == RPAD_X) && ovl_r;

    // Wall reflection is independent of the paddle one, so a corner hit flips both.
    always_comb begin
        dh_d = dh_q;
        dv_d = dv_q;
        if (bounce_l)      dh_d = 1'b1;
        else if (bounce_r) dh_d = 1'b0;
        if (ball_v_q <= BRD)               dv_d = 1'b1;
        else if (ball_v_q + BS >= BOT_LIM) dv_d = 1'b0;
    end

    assign in_area   = (bus.PIXEL_H < H_A) && (bus.PIXEL_V < V_A);
    assign on_border = (bus.PIXEL_H < BRD) || (bus.PIXEL_H >= R_LIM) ||
                       (bus.PIXEL_V < BRD) || (bus.PIXEL_V >= B_LIM);
    assign on_ball   = (state_q != S_OVER) &&
                       (bus.PIXEL_H >= ball_h_q) && (bus.PIXEL_H < ball_h_q + BS) &&
                       (bus.PIXEL_V >= ball_v_q) && (bus.PIXEL_V < ball_v_q + BS);
    assign on_pad    = ((bus.PIXEL_H >= LPAD_X) && (bus.PIXEL_H < LPAD_X + PW) &&
                        (bus.PIXEL_V >= pad_l_top_q) && (bus.PIXEL_V < pad_l_top_q + PL)) ||
                       ((bus.PIXEL_H >= RPAD_X) && (bus.PIXEL_H < RPAD_X + PW) &&
                        (bus.PIXEL_V >= pad_r_top_q) && (bus.PIXEL_V < pad_r_top_q + PL));
    assign on_net    = bus.PIXEL_V[4] && ((bus.PIXEL_H == NET_L) || (bus.PIXEL_H == NET_R));

    always_comb begin
        pixel_d = 3'b000;
        if (in_area) begin
            if (on_border)    pixel_d = 3'b100;
            else if (on_ball) pixel_d = 3'b001;
            else if (on_pad)  pixel_d = 3'b111;
            else if (on_net)  pixel_d = 3'b110;
        end
    end

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            pause_q      <= '0;
            ball_h_q     <= CTR_H;
            ball_v_q     <= CTR_V;
            dh_q         <= 1'b1;
            dv_q         <= 1'b1;
            score_l_q    <= '0;
            score_r_q    <= '0;
            serve_prev_q <= 1'b0;
            pad_l_top_q  <= '0;
            pad_r_top_q  <= '0;
            pixel_q      <= 3'b000;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            pad_l_top_q <= pad_l_top_d;
            pad_r_top_q <= pad_r_top_d;
            pixel_q     <= pixel_d;
            if (tick) begin
                serve_prev_q <= bus.SERVE;
                case (state_q)
                    S_IDLE: begin
                        ball_h_q <= CTR_H;
                        ball_v_q <= CTR_V;
                        if (bus.SERVE) state_q <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (miss_l) begin
                            ball_h_q  <= CTR_H;
                            ball_v_q  <= CTR_V;
                            dh_q      <= 1'b0;
                            pause_q   <= '0;
                            score_r_q <= (score_r_q < WIN4) ? score_r_q + 4'd1 : score_r_q;
                            state_q   <= (score_r_q + 4'd1 >= WIN4) ? S_OVER : S_POINT;
                        end else if (miss_r) begin
                            ball_h_q  <= CTR_H;
                            ball_v_q  <= CTR_V;
                            dh_q      <= 1'b1;
                            pause_q   <= '0;
                            score_l_q <= (score_l_q < WIN4) ? score_l_q + 4'd1 : score_l_q;
                            state_q   <= (score_l_q + 4'd1 >= WIN4) ? S_OVER : S_POINT;
                        end else begin
                            dh_q     <= dh_d;
                            dv_q     <= dv_d;
                            ball_h_q <= dh_d ? ball_h_q + 11'd1 : ball_h_q - 11'd1;
                            ball_v_q <= dv_d ? ball_v_q + 11'd1 : ball_v_q - 11'd1;
                        end
                    end
                    S_POINT: begin
                        if (pause_q == PAUSE_LAST) begin
                            pause_q <= '0;
                            state_q <= bus.SERVE ? S_PLAY : S_IDLE;
                        end else begin
                            pause_q <= pause_q + 1'b1;
                        end
                    end
                    S_OVER: begin
                        if (bus.SERVE && !serve_prev_q) begin
                            score_l_q <= '0;
                            score_r_q <= '0;
                            ball_h_q  <= CTR_H;
                            ball_v_q  <= CTR_V;
                            dh_q      <= 1'b1;
                            dv_q      <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.PIXEL   = pixel_q;
    assign bus.SCORE_L = score_l_q;
    assign bus.SCORE_R = score_r_q;
    assign bus.STATE   = state_q;
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine with a fast tick: hand-derived ball trajectory and pixel checks.
module tb_pong_engine;
    logic VGA_CLOCK = 1'b0;
    logic RESET;
    pong_engine_if bus();

    pong_engine #(
        .TICK_DIV(4), .PAUSE_TICKS(2), .WIN_SCORE(2)
    ) dut (
        .VGA_CLOCK(VGA_CLOCK),
        .RESET    (RESET),
        .bus      (bus)
    );

    always #5 VGA_CLOCK = ~VGA_CLOCK;

    int          checks   = 0;
    int          failures = 0;
    string       tag_q[$];
    logic [15:0] exp_q[$];

    task automatic step(input int n);
        repeat (n) @(posedge VGA_CLOCK);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [15:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    task automatic pix(input string tag, input int h, input int v, input logic [2:0] e);
        bus.PIXEL_H = 11'(h);
        bus.PIXEL_V = 11'(v);
        expect_val(tag, 16'(e));
        step(1);
        check(16'(bus.PIXEL));
    endtask

    task automatic ball(input string tag, input int h, input int v);
        expect_val({tag, "_h"}, 16'(h));
        expect_val({tag, "_v"}, 16'(v));
        check(16'(dut.ball_h_q));
        check(16'(dut.ball_v_q));
    endtask

    initial begin
        RESET = 1'b1;
        bus.PADDLE_L_POS = 8'd0;
        bus.PADDLE_R_POS = 8'd0;
        bus.SERVE = 1'b0;
        bus.PIXEL_H = 11'd0;
        bus.PIXEL_V = 11'd0;
        step(2);

        expect_val("rst_state", 0);   check(16'(bus.STATE));
        expect_val("rst_score_l", 0); check(16'(bus.SCORE_L));
        expect_val("rst_score_r", 0); check(16'(bus.SCORE_R));
        expect_val("rst_pixel", 0);   check(16'(bus.PIXEL));
        expect_val("rst_dh", 1);      check(16'(dut.dh_q));
        expect_val("rst_dv", 1);      check(16'(dut.dv_q));
        ball("rst_ball", 381, 231);

        // Pixel colouring in IDLE with both paddles at the top.
        RESET = 1'b0;
        step(1);
        pix("pix_border_left", 2, 100, 3'b100);
        pix("pix_ball", 385, 240, 3'b001);
        pix("pix_net_on", 389, 16, 3'b110);
        pix("pix_net_gap", 389, 32, 3'b000);
        pix("pix_pad_l_top", 12, 30, 3'b111);
        pix("pix_outside_h", 800, 100, 3'b000);
        pix("pix_outside_v", 100, 600, 3'b000);
        pix("pix_border_bot", 100, 476, 3'b100);
        bus.PADDLE_L_POS = 8'hFF;
        step(1);
        expect_val("pad_l_clamp", 399); check(16'(dut.pad_l_top_q));
        pix("pix_pad_l_clamped", 12, 450, 3'b111);
        pix("pix_pad_l_moved", 12, 30, 3'b000);

        // Rally 1: right paddle returns the ball, top wall bounce, left miss.
        RESET = 1'b1;
        bus.PADDLE_L_POS = 8'd0;
        bus.PADDLE_R_POS = 8'd150;
        bus.SERVE = 1'b1;
        step(2);
        RESET = 1'b0;
        step(3);
        expect_val("serve_before_tick", 0); check(16'(bus.STATE));
        step(1);
        expect_val("serve_first_tick", 1); check(16'(bus.STATE));
        ball("first_tick", 381, 231);
        step(3);
        expect_val("hold_h", 381); check(16'(dut.ball_h_q));
        step(1);
        ball("move1", 382, 232);

        step(4 * 360);
        ball("pre_rbounce", 742, 322);
        expect_val("pre_rbounce_dv", 0); check(16'(dut.dv_q));
        step(4);
        ball("rbounce", 741, 321);
        expect_val("rbounce_dh", 0); check(16'(dut.dh_q));

        step(4 * 316);
        ball("pre_top", 425, 5);
        expect_val("pre_top_dv", 0); check(16'(dut.dv_q));
        step(4);
        ball("top_bounce", 424, 6);
        expect_val("top_bounce_dv", 1); check(16'(dut.dv_q));

        step(4 * 419);
        ball("pre_lmiss", 5, 425);
        expect_val("pre_lmiss_state", 1); check(16'(bus.STATE));
        step(4);
        expect_val("lmiss_score_r", 1); check(16'(bus.SCORE_R));
        expect_val("lmiss_state", 2);   check(16'(bus.STATE));
        expect_val("lmiss_dh", 0);      check(16'(dut.dh_q));
        ball("lmiss_centre", 381, 231);
        step(4);
        expect_val("point_tick1", 2); check(16'(bus.STATE));
        step(4);
        expect_val("point_done", 1); check(16'(bus.STATE));

        // Rally 2: ball heads left and is missed again; game over.
        step(4 * 377);
        expect_val("over_state", 3);   check(16'(bus.STATE));
        expect_val("over_score_r", 2); check(16'(bus.SCORE_R));
        expect_val("over_score_l", 0); check(16'(bus.SCORE_L));
        pix("over_ball_hidden", 385, 240, 3'b000);
        bus.SERVE = 1'b0;
        step(7);
        expect_val("over_hold", 3);       check(16'(bus.STATE));
        expect_val("over_hold_score", 2); check(16'(bus.SCORE_R));
        bus.SERVE = 1'b1;
        step(4);
        expect_val("restart_state", 0);   check(16'(bus.STATE));
        expect_val("restart_score_r", 0); check(16'(bus.SCORE_R));
        expect_val("restart_dh", 1);      check(16'(dut.dh_q));

        // Rally 3: right paddle out of the way, left player scores, then reset mid-play.
        bus.PADDLE_R_POS = 8'd0;
        step(4);
        expect_val("rally3_play", 1); check(16'(bus.STATE));
        step(4 * 378);
        expect_val("rmiss_score_l", 1); check(16'(bus.SCORE_L));
        expect_val("rmiss_state", 2);   check(16'(bus.STATE));
        expect_val("rmiss_dh", 1);      check(16'(dut.dh_q));
        step(8);
        expect_val("rally4_play", 1); check(16'(bus.STATE));
        bus.PIXEL_H = 11'd2;
        bus.PIXEL_V = 11'd100;
        step(12);
        expect_val("pre_reset_pixel", 4);   check(16'(bus.PIXEL));
        expect_val("pre_reset_score_l", 1); check(16'(bus.SCORE_L));
        #2;
        RESET = 1'b1;
        #1;
        expect_val("midplay_rst_state", 0);   check(16'(bus.STATE));
        expect_val("midplay_rst_score_l", 0); check(16'(bus.SCORE_L));
        expect_val("midplay_rst_pixel", 0);   check(16'(bus.PIXEL));
        ball("midplay_rst", 381, 231);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
